mc_control_fsm: RTL

- Multicycle main controller for the 32-bit processor. It is the driving end of the ALU interface: it issues the 4-bit ALU control code and operand selects, and consumes the ALU zero/negative/overflow flags.
- Sequences instruction fetch, decode, execute, memory access and writeback, with a ready handshake to memory.
- Latches compare flags into a status register and raises overflow, illegal-opcode and memory-timeout exceptions.

---
 rtl/mc_ctrl_pkg.sv | 85 ++++++++
 rtl/mc_control_fsm_if.sv | 42 ++++
 rtl/mc_funct_decode.sv | 44 ++++
 rtl/mc_control_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle main controller.
// Contents: FSM state encoding, ALU control codes, opcode/funct values,
// exception cause codes and the datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExecR  = 4'd2,
        StExecI  = 4'd3,
        StAddr   = 4'd4,
        StMemRd  = 4'd5,
        StMemWr  = 4'd6,
        StWbAlu  = 4'd7,
        StWbMem  = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StExc    = 4'd11
    } state_e;

    // ALU control codes
    localparam logic [3:0] AluAnd  = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluSub  = 4'b0011;
    localparam logic [3:0] AluCmp  = 4'b0100;
    localparam logic [3:0] AluBeq  = 4'b0101;
    localparam logic [3:0] AluSll  = 4'b1100;
    localparam logic [3:0] AluSlr  = 4'b1101;
    localparam logic [3:0] AluSllv = 4'b1110;
    localparam logic [3:0] AluSlrv = 4'b1111;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    // R-type funct codes, instruction[5:0]
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSlr  = 6'b000010;
    localparam logic [5:0] FnSllv = 6'b000100;
    localparam logic [5:0] FnSlrv = 6'b000110;
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnCmp  = 6'b101010;

    // Exception causes
    localparam logic [1:0] ExcNone     = 2'd0;
    localparam logic [1:0] ExcOverflow = 2'd1;
    localparam logic [1:0] ExcIllegal  = 2'd2;
    localparam logic [1:0] ExcBusErr   = 2'd3;

    // pc_src
    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcExc    = 2'd3;

    // alu_src_b
    localparam logic [1:0] SrcBReg  = 2'd0;
    localparam logic [1:0] SrcBFour = 2'd1;
    localparam logic [1:0] SrcBSext = 2'd2;
    localparam logic [1:0] SrcBZext = 2'd3;

    // reg_dst
    localparam logic [1:0] RegDstRt = 2'd0;
    localparam logic [1:0] RegDstRd = 2'd1;
    localparam logic [1:0] RegDstRa = 2'd2;

    // mem_to_reg
    localparam logic [1:0] MemToRegAluOut = 2'd0;
    localparam logic [1:0] MemToRegMdr    = 2'd1;
    localparam logic [1:0] MemToRegPc     = 2'd2;

    // States that hold a memory request open and run the wait counter.
    function automatic logic is_mem_wait_state(state_e st);
        return (st == StFetch) || (st == StMemRd) || (st == StMemWr);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/memory bundle.
// master: the controller (drives control, consumes IR fields, ALU flags, mem_ready).
// slave : the datapath side (drives IR fields, flags, mem_ready; consumes control).
interface mc_control_fsm_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_negative;
    logic       alu_overflow;
    logic       mem_ready;

    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] status_flags;
    logic [1:0] exc_cause;

    modport master (
        input  opcode, funct, alu_zero, alu_negative, alu_overflow, mem_ready,
        output alu_ctrl, alu_src_a, alu_src_b, pc_en, pc_src, i_or_d, mem_read,
               mem_write, ir_write, reg_write, reg_dst, mem_to_reg, status_flags,
               exc_cause
    );

    modport slave (
        output opcode, funct, alu_zero, alu_negative, alu_overflow, mem_ready,
        input  alu_ctrl, alu_src_a, alu_src_b, pc_en, pc_src, i_or_d, mem_read,
               mem_write, ir_write, reg_write, reg_dst, mem_to_reg, status_flags,
               exc_cause
    );

endinterface

// File: rtl/mc_funct_decode.sv
// Combinational R-type funct decoder.
// funct_i    : instruction[5:0]
// alu_ctrl_o : ALU op for the funct (ADD when illegal)
// legal_o    : funct is a supported R-type operation
// is_cmp_o   : CMP, which updates the status register instead of a register
// can_ovf_o  : ADD/SUB, the only R-type ops that trap on overflow
module mc_funct_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       legal_o,
    output logic       is_cmp_o,
    output logic       can_ovf_o
);

    always_comb begin
        alu_ctrl_o = AluAdd;
        legal_o    = 1'b1;
        is_cmp_o   = 1'b0;
        can_ovf_o  = 1'b0;
        case (funct_i)
            FnAnd:  alu_ctrl_o = AluAnd;
            FnAdd: begin
                alu_ctrl_o = AluAdd;
                can_ovf_o  = 1'b1;
            end
            FnSub: begin
                alu_ctrl_o = AluSub;
                can_ovf_o  = 1'b1;
            end
            FnCmp: begin
                alu_ctrl_o = AluCmp;
                is_cmp_o   = 1'b1;
            end
            FnSll:  alu_ctrl_o = AluSll;
            FnSlr:  alu_ctrl_o = AluSlr;
            FnSllv: alu_ctrl_o = AluSllv;
            FnSlrv: alu_ctrl_o = AluSlrv;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller: fetch / decode / execute / memory / writeback
// sequencing with a mem_ready handshake, CMP status register and sticky
// exception cause (overflow, illegal opcode/funct, memory timeout).
// clk   : rising-edge clock
// reset : asynchronous active-high reset
// bus   : controller side of mc_control_fsm_if (IR fields, ALU flags,
//         mem_ready in; datapath/memory control, status and cause out)
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  bus
);

    // Last counter value at which a wait cycle may still complete.
    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       status_q, status_d;
    logic [1:0]       cause_q, cause_d;

    logic [3:0] fn_alu_ctrl;
    logic       fn_legal;
    logic       fn_is_cmp;
    logic       fn_can_ovf;

    mc_funct_decode u_funct_decode (
        .funct_i    (bus.funct),
        .alu_ctrl_o (fn_alu_ctrl),
        .legal_o    (fn_legal),
        .is_cmp_o   (fn_is_cmp),
        .can_ovf_o  (fn_can_ovf)
    );

    logic timeout;
    assign timeout = (cnt_q == WaitLast);

    // Next state, wait counter, status and cause.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        status_d = status_q;
        cause_d  = cause_q;

        // Shared wait handling; a mem_ready in the timeout cycle still completes.
        if (is_mem_wait_state(state_q) && !bus.mem_ready) begin
            if (timeout) begin
                state_d = StExc;
                cause_d = ExcBusErr;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                StFetch: state_d = StDecode;
                StDecode: begin
                    case (bus.opcode)
                        OpRtype: begin
                            if (fn_legal) begin
                                state_d = StExecR;
                            end else begin
                                state_d = StExc;
                                cause_d = ExcIllegal;
                            end
                        end
                        OpAddi, OpAndi: state_d = StExecI;
                        OpLw, OpSw:     state_d = StAddr;
                        OpBeq:          state_d = StBranch;
                        OpJ, OpJal:     state_d = StJump;
                        default: begin
                            state_d = StExc;
                            cause_d = ExcIllegal;
                        end
                    endcase
                end
                StExecR: begin
                    if (fn_can_ovf && bus.alu_overflow) begin
                        state_d = StExc;
                        cause_d = ExcOverflow;
                    end else if (fn_is_cmp) begin
                        status_d = {bus.alu_negative, bus.alu_zero, bus.alu_overflow};
                        state_d  = StFetch;
                    end else begin
                        state_d = StWbAlu;
                    end
                end
                StExecI: begin
                    if ((bus.opcode == OpAddi) && bus.alu_overflow) begin
                        state_d = StExc;
                        cause_d = ExcOverflow;
                    end else begin
                        state_d = StWbAlu;
                    end
                end
                StAddr:  state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
                StMemRd: state_d = StWbMem;
                StMemWr: state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StFetch;
            cnt_q    <= '0;
            status_q <= 3'b000;
            cause_q  <= ExcNone;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            cause_q  <= cause_d;
        end
    end

    // Control outputs decoded from the state register. Reset forces the idle
    // values directly so nothing is requested while reset is held, even though
    // the state register already sits in FETCH.
    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;

    always_comb begin
        alu_ctrl   = AluAdd;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        pc_en      = 1'b0;
        pc_src     = PcSrcAlu;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RegDstRt;
        mem_to_reg = MemToRegAluOut;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = SrcBFour;
                    ir_write  = bus.mem_ready;
                    pc_en     = bus.mem_ready;
                end
                StDecode: alu_src_b = SrcBSext;
                StExecR: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = fn_alu_ctrl;
                end
                StExecI: begin
                    alu_src_a = 1'b1;
                    if (bus.opcode == OpAndi) begin
                        alu_src_b = SrcBZext;
                        alu_ctrl  = AluAnd;
                    end else begin
                        alu_src_b = SrcBSext;
                    end
                end
                StAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SrcBSext;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                StWbAlu: begin
                    reg_write = 1'b1;
                    reg_dst   = (bus.opcode == OpRtype) ? RegDstRd : RegDstRt;
                end
                StWbMem: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MemToRegMdr;
                end
                StBranch: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = AluBeq;
                    pc_src    = PcSrcAluOut;
                    pc_en     = bus.alu_zero;
                end
                StJump: begin
                    pc_en  = 1'b1;
                    pc_src = PcSrcJump;
                    if (bus.opcode == OpJal) begin
                        reg_write  = 1'b1;
                        reg_dst    = RegDstRa;
                        mem_to_reg = MemToRegPc;
                    end
                end
                StExc: begin
                    pc_en  = 1'b1;
                    pc_src = PcSrcExc;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_ctrl     = alu_ctrl;
    assign bus.alu_src_a    = alu_src_a;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.pc_en        = pc_en;
    assign bus.pc_src       = pc_src;
    assign bus.i_or_d       = i_or_d;
    assign bus.mem_read     = mem_read;
    assign bus.mem_write    = mem_write;
    assign bus.ir_write     = ir_write;
    assign bus.reg_write    = reg_write;
    assign bus.reg_dst      = reg_dst;
    assign bus.mem_to_reg   = mem_to_reg;
    assign bus.status_flags = status_q;
    assign bus.exc_cause    = cause_q;

endmodule
